write_back_unit: RTL and testbench

- Parametrised write-back stage for the RISC-V pipeline. Accepts retiring instructions from the memory stage over a valid/ready handshake and selects the result source: ALU result, link address, or load data.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends it.
- Drives a registered, single-cycle register-file write port with x0, store, branch, halt and flush suppression.

---
 rtl/write_back_unit_pkg.sv | 31 +++
 rtl/write_back_unit_if.sv | 26 ++
 rtl/write_back_unit_load_extend.sv | 38 +++
 rtl/write_back_unit.sv | 131 +++++++++++++
 tb/tb_write_back_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/write_back_unit_pkg.sv
// Shared constants for the write-back stage: opcodes, load funct3 widths, FSM states.
package write_back_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        DRAIN     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/write_back_unit_if.sv
// Memory-stage input, data-memory response and register-file write port bundle.
interface write_back_unit_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instruction_in;
    logic [XLEN-1:0]       alu_in;
    logic [XLEN-1:0]       link_in;
    logic                  mem_rsp_valid;
    logic [XLEN-1:0]       mem_rdata;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;

    modport master (
        output in_valid, instruction_in, alu_in, link_in, mem_rsp_valid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, instruction_in, alu_in, link_in, mem_rsp_valid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/write_back_unit_load_extend.sv
// Load data alignment and sign/zero extension; purely combinational, no backpressure.
module write_back_unit_load_extend
    import write_back_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  raw,
    output logic [XLEN-1:0]  result
);
    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;

    // Halfword and word accesses ignore the low offset bits below their natural alignment.
    assign half_off = offset & ~OFF_W'(1);
    assign word_off = offset & ~OFF_W'(3);
    assign b = raw[{offset,   3'b000} +: 8];
    assign h = raw[{half_off, 3'b000} +: 16];
    assign w = raw[{word_off, 3'b000} +: 32];

    always_comb begin
        result = raw;
        case (funct3)
            F3_LB:  result = XLEN'($signed(b));
            F3_LBU: result = XLEN'(b);
            F3_LH:  result = XLEN'($signed(h));
            F3_LHU: result = XLEN'(h);
            F3_LW:  result = XLEN'($signed(w));
            F3_LWU: result = (XLEN == 64) ? XLEN'(w) : raw;
            default: result = raw;
        endcase
    end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: result select, load wait/extend, registered 1-cycle rf write; in_ready low outside IDLE or on halt.
// Latency 1 cycle after acceptance (non-load) or after mem_rsp_valid (load). Optional WB_RETIRE_CNT_EN adds retire_cnt.
module write_back_unit
    import write_back_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt,
    input  logic flush,
    write_back_unit_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);
    localparam int OFF_W = $clog2(XLEN/8);

    wb_state_t             state;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [REG_ADDR_W-1:0] cap_rd;
    logic [2:0]            cap_f3;
    logic [OFF_W-1:0]      cap_off;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic                  accept;
    logic                  is_load;
    logic                  writes;
    logic [XLEN-1:0]       sel_data;
    logic [XLEN-1:0]       ext_data;
    logic                  unused_instr;

    assign opcode       = bus.instruction_in[6:0];
    assign rd           = REG_ADDR_W'(bus.instruction_in[11:7]);
    assign funct3       = bus.instruction_in[14:12];
    assign unused_instr = &{1'b0, bus.instruction_in[31:15]};

    assign bus.in_ready = (state == IDLE) && !halt && rst_n;
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;

    always_comb begin
        is_load  = 1'b0;
        writes   = 1'b0;
        sel_data = bus.alu_in;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: writes = 1'b1;
            OPC_JAL, OPC_JALR: begin
                writes   = 1'b1;
                sel_data = bus.link_in;
            end
            OPC_LOAD: is_load = 1'b1;
            default: ;
        endcase
    end

    write_back_unit_load_extend #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extend (
        .funct3 (cap_f3),
        .offset (cap_off),
        .raw    (bus.mem_rdata),
        .result (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cap_rd  <= '0;
            cap_f3  <= '0;
            cap_off <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load) begin
                            cap_rd  <= rd;
                            cap_f3  <= funct3;
                            cap_off <= bus.alu_in[OFF_W-1:0];
                            state   <= WAIT_LOAD;
                        end else if (writes && rd != '0) begin
                            we_q    <= 1'b1;
                            waddr_q <= rd;
                            wdata_q <= sel_data;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (bus.mem_rsp_valid && !flush) begin
                        we_q    <= (cap_rd != '0);
                        waddr_q <= cap_rd;
                        wdata_q <= ext_data;
                        state   <= IDLE;
                    end else if (flush) begin
                        // A flush coinciding with the response consumes it; otherwise wait it out.
                        state <= bus.mem_rsp_valid ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_rsp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic retire_evt;
    assign retire_evt = (state == IDLE && accept && !is_load) ||
                        (state == WAIT_LOAD && bus.mem_rsp_valid && !flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          retire_cnt <= '0;
        else if (retire_evt) retire_cnt <= retire_cnt + 64'd1;
    end
`endif
endmodule

// File: tb/tb_write_back_unit.sv
// Directed self-checking bench for write_back_unit (XLEN=32); inputs driven and outputs sampled on negedge.
module tb_write_back_unit;
    import write_back_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic halt;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    logic [63:0] cnt0;
`endif

    write_back_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

    write_back_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .halt  (halt),
        .flush (flush),
        .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3);
        mk = {17'd0, f3, rd, opc};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] link);
        bus.in_valid       = 1'b1;
        bus.instruction_in = instr;
        bus.alu_in         = alu;
        bus.link_in        = link;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    // Accepts a load, returns the response after 'gap' idle cycles, checks the resulting write.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] rdata, input int gap,
                           input logic [31:0] exp);
        issue(mk(OPC_LOAD, rd, f3), addr, 32'h0);
        for (int i = 0; i < gap; i++) begin
            check({tag, "_wait_rdy"}, bus.in_ready, 1'b0);
            check({tag, "_wait_we"}, bus.rf_we, 1'b0);
            cyc();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check({tag, "_we"}, bus.rf_we, 1'b1);
        check({tag, "_waddr"}, bus.rf_waddr, rd);
        check({tag, "_wdata"}, bus.rf_wdata, exp);
        check({tag, "_rdy_back"}, bus.in_ready, 1'b1);
        cyc();
        check({tag, "_we_pulse"}, bus.rf_we, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.instruction_in = '0; bus.alu_in = '0; bus.link_in = '0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
        cyc();
        check("rst_rdy", bus.in_ready, 1'b0);
        check("rst_we", bus.rf_we, 1'b0);
        check("rst_waddr", bus.rf_waddr, 5'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rst_cnt", retire_cnt, 64'd0);
`endif
        rst_n = 1'b1;
        cyc();
        check("idle_rdy", bus.in_ready, 1'b1);

        // OP ADD rd=5
        issue(mk(OPC_OP, 5'd5, 3'b000), 32'h0000_0123, 32'h0);
        check("add_we", bus.rf_we, 1'b1);
        check("add_waddr", bus.rf_waddr, 5'd5);
        check("add_wdata", bus.rf_wdata, 32'h123);
        cyc();
        check("add_we_pulse", bus.rf_we, 1'b0);

        // STORE then OP rd=0, back to back
`ifdef WB_RETIRE_CNT_EN
        cnt0 = retire_cnt;
`endif
        issue(mk(OPC_STORE, 5'd3, 3'b010), 32'h40, 32'h0);
        check("store_we", bus.rf_we, 1'b0);
        issue(mk(OPC_OP, 5'd0, 3'b000), 32'h55, 32'h0);
        check("x0_we", bus.rf_we, 1'b0);
        cyc();
        check("x0_we2", bus.rf_we, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        check("cnt_plus2", retire_cnt, cnt0 + 64'd2);
`endif

        // Loads: byte/half/word variants
        do_load("lb",  F3_LB,  5'd7, 32'h1000_0002, 32'h0080_0000, 3, 32'hFFFF_FF80);
        do_load("lbu", F3_LBU, 5'd7, 32'h1000_0002, 32'h0080_0000, 3, 32'h0000_0080);
        do_load("lh",  F3_LH,  5'd8, 32'h1000_0002, 32'h8001_1234, 0, 32'hFFFF_8001);
        do_load("lhu", F3_LHU, 5'd8, 32'h1000_0003, 32'h8001_1234, 1, 32'h0000_8001);
        do_load("lw",  F3_LW,  5'd9, 32'h1000_0003, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        // JAL rd=1
        issue(mk(OPC_JAL, 5'd1, 3'b000), 32'h0000_DEAD, 32'h0000_1004);
        check("jal_we", bus.rf_we, 1'b1);
        check("jal_waddr", bus.rf_waddr, 5'd1);
        check("jal_wdata", bus.rf_wdata, 32'h1004);

        // Flush on the accept cycle drops the instruction
        flush = 1'b1;
        issue(mk(OPC_OP_IMM, 5'd9, 3'b000), 32'h77, 32'h0);
        flush = 1'b0;
        check("flush_acc_we", bus.rf_we, 1'b0);

        // LW, flush in WAIT_LOAD, response 2 cycles later
`ifdef WB_RETIRE_CNT_EN
        cnt0 = retire_cnt;
`endif
        issue(mk(OPC_LOAD, 5'd10, F3_LW), 32'h2000_0000, 32'h0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("drain_state", dut.state, DRAIN);
        check("drain_rdy", bus.in_ready, 1'b0);
        cyc();
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h1111_2222;
        check("drain_rdy2", bus.in_ready, 1'b0);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check("drain_we", bus.rf_we, 1'b0);
        check("drain_rdy_back", bus.in_ready, 1'b1);
`ifdef WB_RETIRE_CNT_EN
        check("drain_cnt", retire_cnt, cnt0);
`endif

        // Flush coinciding with the response discards it and returns to IDLE
        issue(mk(OPC_LOAD, 5'd11, F3_LW), 32'h2000_0000, 32'h0);
        flush = 1'b1; bus.mem_rsp_valid = 1'b1;
        cyc();
        flush = 1'b0; bus.mem_rsp_valid = 1'b0;
        check("flush_rsp_we", bus.rf_we, 1'b0);
        check("flush_rsp_rdy", bus.in_ready, 1'b1);

        // halt blocks acceptance
        halt = 1'b1;
        bus.in_valid = 1'b1; bus.instruction_in = mk(OPC_OP, 5'd4, 3'b000); bus.alu_in = 32'h99;
        #1;
        check("halt_rdy", bus.in_ready, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        halt = 1'b0;
        check("halt_we", bus.rf_we, 1'b0);

        // JAL leaves nonzero write outputs, then reset during WAIT_LOAD
        issue(mk(OPC_JAL, 5'd2, 3'b000), 32'h0, 32'h0000_2008);
        check("jal2_wdata", bus.rf_wdata, 32'h2008);
        issue(mk(OPC_LOAD, 5'd12, F3_LW), 32'h3000_0000, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mrst_state", dut.state, IDLE);
        check("mrst_we", bus.rf_we, 1'b0);
        check("mrst_waddr", bus.rf_waddr, 5'd0);
        check("mrst_wdata", bus.rf_wdata, 32'd0);
        check("mrst_rdy", bus.in_ready, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp_we", bus.rf_we, 1'b0);
        check("late_rsp_rdy", bus.in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
